// File: rtl/i2c_cfg_pkg.sv
// Shared types for the I2C configuration sequencer: FSM states, table entry
// type and the clock-divider / address-width helpers.
package i2c_cfg_pkg;

    localparam int ENTRY_W = 24;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_ARM   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_CHECK = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Terminal count of the half-period counter.
    function automatic int calc_div(input int clk_freq, input int i2c_freq);
        return clk_freq / (2 * i2c_freq) - 1;
    endfunction

    // A one-entry table still needs a one-bit address port.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_cfg_clkdiv.sv
// Divides the system clock down to the controller clock and produces a
// one-cycle enable on every falling toggle of that clock.
module i2c_cfg_clkdiv
    import i2c_cfg_pkg::*;
#(
    parameter int DIV = 1249
) (
    input  logic clk,
    input  logic rst_n,
    output logic i2c_clk,
    output logic ce
);

    localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [CW-1:0] TC = CW'(DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic          tc;

    always_comb begin
        tc    = (cnt_q == TC);
        cnt_d = tc ? '0 : cnt_q + 1'b1;
        clk_d = tc ? ~clk_q : clk_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    // High in the cycle whose closing edge drops i2c_clk, so sequencer
    // updates land on the same edge as the falling toggle.
    assign ce      = tc & clk_q;
    assign i2c_clk = clk_q;

endmodule

// File: rtl/i2c_cfg_seq.sv
// Walks a table of 24-bit register writes and hands each to an I2C controller.
// Define I2C_CFG_RETRY_EN to retry NACKed entries up to RETRY_MAX times.
module i2c_cfg_seq
    import i2c_cfg_pkg::*;
#(
    parameter int  CLK_FREQ   = 50_000_000,
    parameter int  I2C_FREQ   = 20_000,
    parameter int  LUT_SIZE   = 32,
    parameter int  AUTO_START = 1,
    parameter int  RETRY_MAX  = 3,
    localparam int AW         = addr_w(LUT_SIZE)
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          start,
    output logic          i2c_clk,
    output logic [23:0]   i2c_data,
    output logic          i2c_go,
    input  logic          i2c_end,
    input  logic          i2c_ack,
    output logic [AW-1:0] lut_addr,
    input  logic [23:0]   lut_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    if (LUT_SIZE < 1 || LUT_SIZE > 256 || RETRY_MAX < 0) begin : g_bad_param
        $error("i2c_cfg_seq: LUT_SIZE must be 1..256 and RETRY_MAX non-negative");
    end

    localparam int DIV = calc_div(CLK_FREQ, I2C_FREQ);
    localparam logic [AW-1:0] LAST = AW'(LUT_SIZE - 1);

    logic ce;

    i2c_cfg_clkdiv #(
        .DIV (DIV)
    ) u_clkdiv (
        .clk     (CLOCK),
        .rst_n   (RESET),
        .i2c_clk (i2c_clk),
        .ce      (ce)
    );

    state_t        state_q, state_d;
    logic [AW-1:0] index_q, index_d;
    logic [AW-1:0] lut_addr_q, lut_addr_d;
    entry_t        data_q, data_d;
    logic          go_q, go_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ack_q, ack_d;
    logic          start_pend_q, start_pend_d;
    logic          auto_pend_q, auto_pend_d;
    logic          run_req;
    logic          advance;

`ifdef I2C_CFG_RETRY_EN
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    logic [RW-1:0] retry_q, retry_d;
`endif

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        lut_addr_d   = lut_addr_q;
        data_d       = data_q;
        go_d         = go_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        ack_d        = ack_q;
        auto_pend_d  = auto_pend_q;
        advance      = 1'b0;
        // A request seen while a run is in progress is dropped, not queued.
        start_pend_d = start_pend_q | (start & ~busy_q);
        run_req      = start_pend_d | auto_pend_q;
`ifdef I2C_CFG_RETRY_EN
        retry_d      = retry_q;
`endif
        if (ce) begin
            start_pend_d = 1'b0;
            auto_pend_d  = 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (run_req) begin
                        state_d = ST_FETCH;
                        index_d = '0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
`ifdef I2C_CFG_RETRY_EN
                        retry_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    lut_addr_d = index_q;
                    state_d    = ST_ISSUE;
                end
                ST_ISSUE: begin
                    data_d  = lut_data;
                    go_d    = 1'b1;
                    state_d = ST_ARM;
                end
                // END can still be high from the previous transfer.
                ST_ARM: begin
                    if (!i2c_end) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (i2c_end) begin
                        ack_d   = i2c_ack;
                        go_d    = 1'b0;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
`ifdef I2C_CFG_RETRY_EN
                    if (ack_q && (retry_q < RETRY_LIM)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        err_d   = err_q | ack_q;
                        advance = 1'b1;
                    end
`else
                    err_d   = err_q | ack_q;
                    advance = 1'b1;
`endif
                end
                default: state_d = ST_IDLE;
            endcase

            if (advance) begin
`ifdef I2C_CFG_RETRY_EN
                retry_d = '0;
`endif
                if (index_q == LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            lut_addr_q   <= '0;
            data_q       <= '0;
            go_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ack_q        <= 1'b0;
            start_pend_q <= 1'b0;
            auto_pend_q  <= (AUTO_START != 0);
`ifdef I2C_CFG_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            lut_addr_q   <= lut_addr_d;
            data_q       <= data_d;
            go_q         <= go_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ack_q        <= ack_d;
            start_pend_q <= start_pend_d;
            auto_pend_q  <= auto_pend_d;
`ifdef I2C_CFG_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    assign i2c_data = data_q;
    assign i2c_go   = go_q;
    assign lut_addr = lut_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Directed bench for i2c_cfg_seq with a behavioural I2C controller, a table
// model and an in-order scoreboard of expected transfers.
module tb_i2c_cfg_seq;

    localparam int CLK_FREQ  = 1000;
    localparam int I2C_FREQ  = 100;
    localparam int LUT_SIZE  = 4;
    localparam int RETRY_MAX = 3;
    localparam int XFER_LEN  = 60;

    logic        CLOCK    = 1'b0;
    logic        RESET    = 1'b0;
    logic        start    = 1'b0;
    logic        i2c_end  = 1'b1;
    logic        i2c_ack  = 1'b0;
    logic [23:0] lut_data = '0;
    logic        i2c_clk, i2c_go, busy, done, err;
    logic [23:0] i2c_data;
    logic [1:0]  lut_addr;

    logic [23:0] lut [LUT_SIZE];
    logic [23:0] exp_q[$];
    int          issue_cnt [LUT_SIZE];

    int pass_cnt  = 0;
    int check_cnt = 0;
    int xfer_cnt  = 0;
    int ce_bad    = 0;
    int fall_cnt  = 0;
    int nack_idx  = -1;
    int nack_left = 0;
    int base      = 0;

    logic go_prev  = 1'b0;
    logic active   = 1'b0;
    logic nack_now = 1'b0;
    logic prev_ce  = 1'b0;
    logic prev_clk = 1'b0;
    logic falling;
    int   timer    = 0;
    int   gap      = 1000;
    int   hi_cnt, lo_cnt;

    i2c_cfg_seq #(
        .CLK_FREQ   (CLK_FREQ),
        .I2C_FREQ   (I2C_FREQ),
        .LUT_SIZE   (LUT_SIZE),
        .AUTO_START (1),
        .RETRY_MAX  (RETRY_MAX)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .start    (start),
        .i2c_clk  (i2c_clk),
        .i2c_data (i2c_data),
        .i2c_go   (i2c_go),
        .i2c_end  (i2c_end),
        .i2c_ack  (i2c_ack),
        .lut_addr (lut_addr),
        .lut_data (lut_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        check_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic push_entry(input int k);
        exp_q.push_back(lut[k]);
    endtask

    task automatic push_all();
        for (int k = 0; k < LUT_SIZE; k++) exp_q.push_back(lut[k]);
    endtask

    task automatic clear_issue();
        for (int k = 0; k < LUT_SIZE; k++) issue_cnt[k] = 0;
        base = xfer_cnt;
    endtask

    task automatic pulse_start();
        @(negedge CLOCK);
        start = 1'b1;
        @(negedge CLOCK);
        start = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        for (int i = 0; i < 200 && busy !== 1'b1; i++) @(negedge CLOCK);
        check(tag, busy, 1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 5000 && done !== 1'b1; i++) @(negedge CLOCK);
        check(tag, done, 1);
    endtask

    task automatic do_run(input string tag);
        pulse_start();
        wait_busy({tag, "_busy"});
        wait_done({tag, "_done"});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_i2c_clk"}, i2c_clk, 0);
        check({tag, "_i2c_go"}, i2c_go, 0);
        check({tag, "_i2c_data"}, i2c_data, 0);
        check({tag, "_lut_addr"}, lut_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Table model, controller model and ce alignment monitor, all on the
    // falling system-clock edge so DUT outputs are sampled between edges.
    initial begin
        forever begin
            @(negedge CLOCK);
            lut_data = lut[lut_addr];
            if (!RESET) begin
                go_prev  = 1'b0;
                active   = 1'b0;
                timer    = 0;
                i2c_end  = 1'b1;
                i2c_ack  = 1'b0;
                gap      = 1000;
                prev_ce  = 1'b0;
                prev_clk = 1'b0;
            end else begin
                falling = prev_clk & ~i2c_clk;
                if (falling !== prev_ce) ce_bad++;
                if (falling) fall_cnt++;
                prev_ce  = dut.ce;
                prev_clk = i2c_clk;

                if (i2c_go && !go_prev) begin
                    xfer_cnt++;
                    check("go_gap", gap >= 10, 1);
                    check("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("issue_data", i2c_data, exp_q.pop_front());
                    nack_now = 1'b0;
                    for (int k = 0; k < LUT_SIZE; k++) begin
                        if (i2c_data == lut[k]) begin
                            issue_cnt[k]++;
                            if (k == nack_idx && nack_left > 0) begin
                                nack_now = 1'b1;
                                nack_left--;
                            end
                        end
                    end
                    active = 1'b1;
                    timer  = 0;
                end
                if (!i2c_go) gap++;
                else gap = 0;
                if (active) begin
                    timer++;
                    if (timer == 4) i2c_end = 1'b0;
                    if (timer == XFER_LEN) begin
                        i2c_end = 1'b1;
                        i2c_ack = nack_now;
                        active  = 1'b0;
                    end
                end
                go_prev = i2c_go;
            end
        end
    end

    initial begin
        for (int k = 0; k < LUT_SIZE; k++)
            lut[k] = {8'(8'h40 + k), 16'($urandom_range(0, 65535))};

        // Reset state
        RESET = 1'b0;
        repeat (3) @(negedge CLOCK);
        check_reset_values("rst");

        // Auto-start run after reset release
        clear_issue();
        push_all();
        RESET = 1'b1;
        wait_busy("auto_busy");
        wait_done("auto_done");
        check("auto_busy_low", busy, 0);
        check("auto_err", err, 0);
        check("auto_sb_empty", exp_q.size(), 0);
        check("auto_xfers", xfer_cnt - base, 4);

        // Controller clock: 5 cycles high, 5 low
        for (int i = 0; i < 50 && i2c_clk !== 1'b0; i++) @(negedge CLOCK);
        for (int i = 0; i < 50 && i2c_clk !== 1'b1; i++) @(negedge CLOCK);
        hi_cnt = 0;
        for (int i = 0; i < 50 && i2c_clk === 1'b1; i++) begin
            hi_cnt++;
            @(negedge CLOCK);
        end
        lo_cnt = 0;
        for (int i = 0; i < 50 && i2c_clk === 1'b0; i++) begin
            lo_cnt++;
            @(negedge CLOCK);
        end
        check("clk_high_cycles", hi_cnt, 5);
        check("clk_low_cycles", lo_cnt, 5);

        // Rerun after done; start while busy is ignored
        clear_issue();
        push_all();
        pulse_start();
        wait_busy("rerun_busy");
        check("rerun_done_cleared", done, 0);
        pulse_start();
        wait_done("rerun_done");
        repeat (300) @(negedge CLOCK);
        check("busy_start_ignored", xfer_cnt - base, 4);
        check("rerun_done_held", done, 1);
        check("rerun_sb_empty", exp_q.size(), 0);

`ifdef I2C_CFG_RETRY_EN
        // Entry 2 NACKs twice, then succeeds
        clear_issue();
        nack_idx  = 2;
        nack_left = 2;
        push_entry(0); push_entry(1); push_entry(2); push_entry(2); push_entry(2); push_entry(3);
        do_run("retry2");
        check("retry2_e2_issues", issue_cnt[2], 3);
        check("retry2_err", err, 0);
        check("retry2_sb_empty", exp_q.size(), 0);

        // Entry 2 always NACKs: give up after RETRY_MAX retries and move on
        clear_issue();
        nack_left = 1000;
        push_entry(0); push_entry(1); push_entry(2); push_entry(2); push_entry(2); push_entry(2);
        push_entry(3);
        do_run("retryx");
        check("retryx_e2_issues", issue_cnt[2], 4);
        check("retryx_e3_issues", issue_cnt[3], 1);
        check("retryx_err", err, 1);
        check("retryx_sb_empty", exp_q.size(), 0);
`else
        // Entry 1 NACKs: flagged once and the run continues
        clear_issue();
        nack_idx  = 1;
        nack_left = 1000;
        push_all();
        do_run("nack1");
        check("nack1_e1_issues", issue_cnt[1], 1);
        check("nack1_e3_issues", issue_cnt[3], 1);
        check("nack1_err", err, 1);
        check("nack1_sb_empty", exp_q.size(), 0);
`endif
        nack_idx  = -1;
        nack_left = 0;

        // err is sticky until the next run starts
        repeat (100) @(negedge CLOCK);
        check("err_sticky", err, 1);
        clear_issue();
        push_all();
        pulse_start();
        wait_busy("clr_busy");
        check("err_cleared", err, 0);
        wait_done("clr_done");
        check("clr_err_final", err, 0);

        // Asynchronous reset during the WAIT of entry 2, then restart at entry 0
        clear_issue();
        push_all();
        pulse_start();
        wait_busy("abort_busy");
        for (int i = 0; i < 2000 && (xfer_cnt - base) < 3; i++) @(negedge CLOCK);
        check("abort_reached_e2", xfer_cnt - base, 3);
        repeat (30) @(negedge CLOCK);
        check("abort_go_high", i2c_go, 1);
        check("abort_busy_high", busy, 1);
        #2;
        RESET = 1'b0;
        #1;
        check_reset_values("async_rst");
        exp_q.delete();
        clear_issue();
        push_all();
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        wait_busy("restart_busy");
        wait_done("restart_done");
        check("restart_xfers", xfer_cnt - base, 4);
        check("restart_e0_issues", issue_cnt[0], 1);
        check("restart_sb_empty", exp_q.size(), 0);
        check("restart_err", err, 0);

        check("ce_on_falling_toggle", ce_bad, 0);
        check("ce_seen", fall_cnt > 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/i2c_cfg_seq.md
I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter CLK_FREQ, 50_000_000, CLOCK frequency in Hz.
REQ-003 SHALL have parameter I2C_FREQ, 20_000, controller clock frequency in Hz.
REQ-004 SHALL have parameter LUT_SIZE, 32, number of 24-bit register-write entries (1..256).
REQ-005 SHALL have parameter AUTO_START, 1, run the table once after reset release.
REQ-006 SHALL have parameter RETRY_MAX, 3, NACK retries per entry (retry build only).
REQ-007 SHALL have port CLOCK in 1, system clock.
REQ-008 SHALL have port RESET in 1, asynchronous active-low reset.
REQ-009 SHALL have port start in 1, single-cycle request to re-run the table.
REQ-010 SHALL have port i2c_clk out 1, divided clock driving the controller's CLOCK.
REQ-011 SHALL have port i2c_data out 24, {slave addr, sub addr, data} to the controller.
REQ-012 SHALL have port i2c_go out 1, transfer request to the controller.
REQ-013 SHALL have ports i2c_end in 1 and i2c_ack in 1, controller completion flag and NACK flag (1 = NACK).
REQ-014 SHALL have ports lut_addr out clog2(LUT_SIZE) and lut_data in 24, synchronous table read with 1-ce latency.
REQ-015 SHALL have ports busy out 1, done out 1 and err out 1.

Function
REQ-016 SHALL generate i2c_clk by toggling at divider terminal count DIV = CLK_FREQ/(2*I2C_FREQ)-1, with the counter wrapping to 0; the default DIV is 1249.
REQ-017 SHALL assert internal ce for exactly one CLOCK cycle at each i2c_clk falling toggle, and SHALL update all sequencer state and outputs only on ce.
REQ-018 SHALL sample i2c_end and i2c_ack only on ce.
REQ-019 SHALL implement the FSM states IDLE, FETCH, ISSUE, ARM, WAIT, CHECK and DONE.
REQ-020 In IDLE, start (latched until the next ce), or the first ce after reset when AUTO_START=1, SHALL go to FETCH with index=0, busy=1, done=0 and err=0.
REQ-021 FETCH SHALL drive lut_addr=index and go to ISSUE on the next ce.
REQ-022 ISSUE SHALL latch i2c_data=lut_data, set i2c_go=1 and go to ARM.
REQ-023 ARM SHALL wait for i2c_end=0, because END may still be high from the previous transfer, and then go to WAIT.
REQ-024 WAIT SHALL wait for i2c_end=1 and then go to CHECK with i2c_go=0.
REQ-025 i2c_go SHALL be low for at least one ce between transfers.
REQ-026 CHECK with ack=0 SHALL go to DONE if index==LUT_SIZE-1, and otherwise SHALL increment index, clear the retry count and go to FETCH.
REQ-027 CHECK with ack=1 SHALL follow REQ-036/REQ-037.
REQ-028 DONE SHALL set busy=0 and done=1, hold both, and return to IDLE; start SHALL be accepted from DONE/IDLE only.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 index SHALL never exceed LUT_SIZE-1, including for LUT_SIZE=1 and LUT_SIZE=256.

Reset
REQ-031 Reset SHALL force: i2c_clk=0, divider=0, i2c_go=0, i2c_data=0, lut_addr=0, busy=0, done=0, err=0, state=IDLE, index=0 and retry count=0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately.
REQ-033 i2c_go SHALL be low from reset assertion, so the controller counter returns to 0.
REQ-034 After reset release with AUTO_START=1, the table SHALL restart from entry 0.
REQ-035 err SHALL be sticky until the next run start or reset.

Configuration
REQ-036 With macro I2C_CFG_RETRY_EN defined, a NACK with retry count < RETRY_MAX SHALL increment the count and go to FETCH with the same index; at RETRY_MAX it SHALL set err=1 and advance as for ack=0.
REQ-037 Without I2C_CFG_RETRY_EN, a NACK SHALL set err=1 and advance immediately; RETRY_MAX and the retry counter are then unused and SHALL NOT be synthesised.

Structure
REQ-038 Package i2c_cfg_pkg SHALL hold the FSM state enum, the 24-bit entry typedef and the DIV computation function.
REQ-039 Sub-module i2c_cfg_clkdiv SHALL contain the divider, the i2c_clk register and ce generation; the sequencer FSM SHALL stay in i2c_cfg_seq.

Verification
REQ-040 With CLK_FREQ=1000, I2C_FREQ=100, AUTO_START=1, LUT_SIZE=4 and a behavioural controller that always ACKs, the bench SHALL see 4 GO pulses with i2c_data equal to entries 0..3 in order, then done=1, busy=0 and err=0.
REQ-041 With the i2c_clk period measured in the REQ-040 configuration, the bench SHALL see 10 CLOCK cycles, 5 high and 5 low, and ce coincident with every falling toggle.
REQ-042 With I2C_CFG_RETRY_EN, RETRY_MAX=3 and entry 2 NACKing twice, the bench SHALL see entry 2 issued 3 times and err=0; with entry 2 always NACKing, entry 2 SHALL be issued 4 times, err=1 and entry 3 still issued.
REQ-043 Without I2C_CFG_RETRY_EN and entry 1 NACKing, the bench SHALL see entry 1 issued once, err=1 and entries 2..3 issued.
REQ-044 With RESET asserted during the WAIT of entry 2, the bench SHALL see all outputs at reset values within 0 cycles (asynchronous), and after release the run SHALL restart at entry 0.
REQ-045 With start pulsed while busy=1, it SHALL be ignored; with start pulsed after done, done SHALL clear and all entries SHALL be reissued.
